systolic_tile_controller: RTL and testbench

Top-level sequencer for one systolic-array tile pass. On a start request it runs three phases: weight load, wavefront compute and result drain. It drives the array's per-row load_weight and enable_mult controls and the weight-row address, and hands results to the writeback path through a valid/ready handshake. It reports busy and a one-cycle done, and supports freeze (en) and abort.

---
 rtl/systolic_tile_controller.sv | 177 +++++++++++++++++
 tb/tb_systolic_tile_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_tile_controller.sv
// systolic_tile_controller: weight-load / wavefront-compute / result-drain sequencer for one tile pass.
// Optional macro STALL_COUNT_EN adds stall_cycles, counting drain beats refused by writeback.
module systolic_tile_controller #(
    parameter int MATRIX_SIZE  = 2,
    parameter int STAGE_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           en,
    input  logic                           start,
    input  logic                           abort,
    output logic                           busy,
    output logic [MATRIX_SIZE-1:0]         load_weight,
    output logic [$clog2(MATRIX_SIZE)-1:0] w_row,
    output logic [MATRIX_SIZE-1:0]         enable_mult,
    output logic                           out_valid,
    output logic [$clog2(MATRIX_SIZE)-1:0] out_row,
    input  logic                           out_ready,
`ifdef STALL_COUNT_EN
    output logic [15:0]                    stall_cycles,
`endif
    output logic                           done
);
    localparam int N  = MATRIX_SIZE;
    localparam int RW = $clog2(N);
    localparam int CW = $clog2((2*N-1)*STAGE_CYCLES+1);
    localparam int SW = STAGE_CYCLES > 1 ? $clog2(STAGE_CYCLES) : 1;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_COMPUTE = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [CW-1:0] step_q, step_d;
    logic          busy_q, busy_d, out_valid_q, out_valid_d, done_q, done_d;
    logic [N-1:0]  load_weight_q, load_weight_d, enable_mult_q, enable_mult_d;
    logic [RW-1:0] w_row_q, w_row_d, out_row_q, out_row_d;
`ifdef STALL_COUNT_EN
    logic [15:0]   stall_q, stall_d;
    assign stall_cycles = stall_q;
`endif

    assign busy        = busy_q;
    assign load_weight = load_weight_q;
    assign w_row       = w_row_q;
    assign enable_mult = enable_mult_q;
    assign out_valid   = out_valid_q;
    assign out_row     = out_row_q;
    assign done        = done_q;

    // Row i (bit N-1-i) is active for steps i..i+N-1, so the wavefront enters at the MSB.
    function automatic logic [N-1:0] wave(input logic [CW-1:0] k);
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) m[N-1-i] = int'(k) >= i && int'(k) <= i + N - 1;
        return m;
    endfunction

    always_comb begin
        state_d       = state_q;
        sub_d         = sub_q;
        step_d        = step_q;
        busy_d        = busy_q;
        load_weight_d = load_weight_q;
        w_row_d       = w_row_q;
        enable_mult_d = enable_mult_q;
        out_valid_d   = out_valid_q;
        out_row_d     = out_row_q;
        done_d        = done_q;
`ifdef STALL_COUNT_EN
        stall_d       = stall_q;
`endif
        if (abort) begin
            state_d       = S_IDLE;
            sub_d         = '0;
            step_d        = '0;
            busy_d        = 1'b0;
            load_weight_d = '0;
            w_row_d       = '0;
            enable_mult_d = '0;
            out_valid_d   = 1'b0;
            out_row_d     = '0;
            done_d        = 1'b0;
        end else if (en) begin
            case (state_q)
                S_IDLE: if (start) begin
                    state_d       = S_LOAD;
                    busy_d        = 1'b1;
                    load_weight_d = '1;
                    w_row_d       = '0;
`ifdef STALL_COUNT_EN
                    stall_d       = '0;
`endif
                end
                S_LOAD: if (w_row_q == RW'(N-1)) begin
                    state_d       = S_COMPUTE;
                    load_weight_d = '0;
                    w_row_d       = '0;
                    sub_d         = '0;
                    step_d        = '0;
                    enable_mult_d = wave('0);
                end else begin
                    w_row_d = w_row_q + 1'b1;
                end
                S_COMPUTE: if (sub_q == SW'(STAGE_CYCLES-1)) begin
                    sub_d = '0;
                    if (step_q == CW'(2*N-2)) begin
                        state_d       = S_DRAIN;
                        step_d        = '0;
                        enable_mult_d = '0;
                        out_valid_d   = 1'b1;
                        out_row_d     = '0;
                    end else begin
                        step_d        = step_q + 1'b1;
                        enable_mult_d = wave(step_q + 1'b1);
                    end
                end else begin
                    sub_d = sub_q + 1'b1;
                end
                S_DRAIN: if (out_ready) begin
                    if (out_row_q == RW'(N-1)) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b0;
                        out_row_d   = '0;
                        done_d      = 1'b1;
                    end else begin
                        out_row_d = out_row_q + 1'b1;
                    end
                end else begin
`ifdef STALL_COUNT_EN
                    stall_d = stall_q == 16'hFFFF ? stall_q : stall_q + 16'd1;
`endif
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            sub_q         <= '0;
            step_q        <= '0;
            busy_q        <= 1'b0;
            load_weight_q <= '0;
            w_row_q       <= '0;
            enable_mult_q <= '0;
            out_valid_q   <= 1'b0;
            out_row_q     <= '0;
            done_q        <= 1'b0;
`ifdef STALL_COUNT_EN
            stall_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            sub_q         <= sub_d;
            step_q        <= step_d;
            busy_q        <= busy_d;
            load_weight_q <= load_weight_d;
            w_row_q       <= w_row_d;
            enable_mult_q <= enable_mult_d;
            out_valid_q   <= out_valid_d;
            out_row_q     <= out_row_d;
            done_q        <= done_d;
`ifdef STALL_COUNT_EN
            stall_q       <= stall_d;
`endif
        end
    end
endmodule

// File: tb/tb_systolic_tile_controller.sv
// tb_systolic_tile_controller: table and sequence checks of the tile sequencer (N=2/S=4 and N=4/S=1),
// with a row scoreboard on each drain port.
module tb_systolic_tile_controller;
    logic clk = 0, reset_n = 0, en = 1, start = 0, start2 = 0, abort = 0, out_ready = 1;
    logic       busy, wr, ov, orow, done;
    logic [1:0] lw, em;
    logic       busy2, ov2, done2;
    logic [3:0] lw2, em2;
    logic [1:0] wr2, orow2;
`ifdef STALL_COUNT_EN
    logic [15:0] stall, stall2;
`endif
    logic [8:0] obs;
    int checks = 0, errors = 0, cyc = 0;
    int q1[$], q2[$];

    typedef struct {int c; logic [8:0] e;} vec_t;
    vec_t tbl[18];
    logic [3:0] em_tbl[7];

    always #5 clk = ~clk;
    assign obs = {busy, lw, wr, em, ov, orow, done};

    systolic_tile_controller #(.MATRIX_SIZE(2), .STAGE_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .start(start), .abort(abort),
        .busy(busy), .load_weight(lw), .w_row(wr), .enable_mult(em),
        .out_valid(ov), .out_row(orow), .out_ready(out_ready),
`ifdef STALL_COUNT_EN
        .stall_cycles(stall),
`endif
        .done(done));

    systolic_tile_controller #(.MATRIX_SIZE(4), .STAGE_CYCLES(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .en(en), .start(start2), .abort(abort),
        .busy(busy2), .load_weight(lw2), .w_row(wr2), .enable_mult(em2),
        .out_valid(ov2), .out_row(orow2), .out_ready(out_ready),
`ifdef STALL_COUNT_EN
        .stall_cycles(stall2),
`endif
        .done(done2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [8:0] pk(input logic b, input logic [1:0] l, input logic w,
                                      input logic [1:0] m, input logic v, input logic r, input logic d);
        return {b, l, w, m, v, r, d};
    endfunction

    // w_row is only meaningful while loading, out_row only while valid
    task automatic ck(input string nm, input logic [8:0] e);
        logic [8:0] m;
        m = 9'h1FF & ~(e[7:6] == 2'b00 ? 9'h020 : 9'h000) & ~(e[2] ? 9'h000 : 9'h002);
        chk(nm, 32'(obs & m), 32'(e & m));
    endtask

    task automatic tick();
        if (reset_n && en && !abort && out_ready) begin
            if (ov) begin
                if (q1.size() == 0) chk("sb1_unexpected_beat", 1, 0);
                else chk("sb1_row", 32'(orow), 32'(q1.pop_front()));
            end
            if (ov2) begin
                if (q2.size() == 0) chk("sb2_unexpected_beat", 1, 0);
                else chk("sb2_row", 32'(orow2), 32'(q2.pop_front()));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic begin_pass();
        cyc = 0;
        start = 1;
        q1.push_back(0);
        q1.push_back(1);
        tick();
        start = 0;
    endtask

    task automatic run_table(input string nm);
        begin_pass();
        for (int i = 0; i < 18; i++) begin
            chk({nm, "_cyc"}, cyc, tbl[i].c);
            ck(nm, tbl[i].e);
            if (i < 17) tick();
        end
    endtask

    initial begin
        for (int c = 1; c <= 18; c++) begin
            logic [1:0] m;
            m = (c >= 3 && c <= 6) ? 2'b10 : (c >= 7 && c <= 10) ? 2'b11 : (c >= 11 && c <= 14) ? 2'b01 : 2'b00;
            tbl[c-1].c = c;
            tbl[c-1].e = pk(c <= 17, c <= 2 ? 2'b11 : 2'b00, c == 2, m, c == 15 || c == 16, c == 16, c == 17);
        end
        em_tbl = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};

        #12;
        chk("reset_outs", 32'(obs), 0);
        chk("reset_outs2", 32'({busy2, lw2, wr2, em2, ov2, orow2, done2}), 0);
        reset_n = 1;
        tick();

        run_table("t1");

        begin_pass();
        while (cyc < 15) tick();
        for (int i = 0; i < 5; i++) begin
            ck("t2_hold", pk(1, 0, 0, 0, 1, 0, 0));
            if (i == 0) out_ready = 0;
            tick();
        end
        out_ready = 1;
        ck("t2_beat0", pk(1, 0, 0, 0, 1, 0, 0));
        tick();
        ck("t2_beat1", pk(1, 0, 0, 0, 1, 1, 0));
        tick();
        ck("t2_done", pk(1, 0, 0, 0, 0, 0, 1));
        tick();
        ck("t2_idle", 9'h000);
`ifdef STALL_COUNT_EN
        chk("t2_stall", 32'(stall), 5);
`endif

        begin_pass();
`ifdef STALL_COUNT_EN
        chk("t3_stall_clr", 32'(stall), 0);
`endif
        while (cyc < 7) tick();
        ck("t3_k1", pk(1, 0, 0, 2'b11, 0, 0, 0));
        en = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            ck("t3_frozen", pk(1, 0, 0, 2'b11, 0, 0, 0));
        end
        en = 1;
        while (cyc < 19) tick();
        chk("t3_no_early_done", 32'(done), 0);
        tick();
        ck("t3_done", pk(1, 0, 0, 0, 0, 0, 1));
        en = 0;
        tick();
        tick();
        ck("t3_done_frozen", pk(1, 0, 0, 0, 0, 0, 1));
        en = 1;
        tick();
        ck("t3_after_done", 9'h000);

        begin_pass();
        while (cyc < 8) tick();
        abort = 1;
        tick();
        chk("t4_abort", 32'(obs), 0);
        abort = 0;
        q1.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_stay_idle", 32'(obs), 0);
        end
        run_table("t4_rerun");

        cyc = 0;
        start = 1;
        q1.push_back(0);
        q1.push_back(1);
        tick();
        while (cyc < 17) tick();
        ck("t5_done", pk(1, 0, 0, 0, 0, 0, 1));
        tick();
        ck("t5_idle_gap", 9'h000);
        q1.push_back(0);
        q1.push_back(1);
        tick();
        ck("t5_reload", pk(1, 2'b11, 0, 0, 0, 0, 0));
        abort = 1;
        tick();
        chk("t5_abort", 32'(obs), 0);
        tick();
        chk("t5_abort_beats_start", 32'(obs), 0);
        abort = 0;
        start = 0;
        q1.delete();
        tick();

        begin_pass();
        while (cyc < 15) tick();
        ck("t6_drain", pk(1, 0, 0, 0, 1, 0, 0));
        #2 reset_n = 0;
        #1;
        chk("t6_async_reset", 32'(obs), 0);
        q1.delete();
        @(negedge clk);
        reset_n = 1;
        tick();
        chk("t6_idle", 32'(obs), 0);
        tick();
        chk("t6_no_done", 32'(done), 0);
`ifdef STALL_COUNT_EN
        chk("t6_stall_reset", 32'(stall), 0);
`endif

        cyc = 0;
        start2 = 1;
        for (int r = 0; r < 4; r++) q2.push_back(r);
        tick();
        start2 = 0;
        for (int c = 1; c <= 4; c++) begin
            chk("n4_load", 32'({lw2, wr2}), 32'({4'b1111, 2'(c - 1)}));
            tick();
        end
        for (int c = 5; c <= 11; c++) begin
            chk("n4_wave", 32'({lw2, em2}), 32'({4'b0000, em_tbl[c-5]}));
            tick();
        end
        for (int c = 12; c <= 15; c++) begin
            chk("n4_valid", 32'({ov2, em2}), 32'({1'b1, 4'b0000}));
            tick();
        end
        chk("n4_done", 32'({busy2, done2}), 2'b11);
        tick();
        chk("n4_idle", 32'({busy2, done2}), 0);

        chk("sb1_leftover", q1.size(), 0);
        chk("sb2_leftover", q2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
